// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES bytes substituted per beat, valid/ready on both sides.
// Define INV_SBOX_EN to build the inverse S-box path selected by in_inverse.
module sub_bytes_iter #(
  parameter int LANES   = 4,
  parameter int N_BYTES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inverse,
  input  logic [8*N_BYTES-1:0] in_block,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*N_BYTES-1:0] out_block,
  output logic                 busy
);

  localparam int NB = N_BYTES / LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = $clog2(8 * N_BYTES);
  localparam logic [BW-1:0] LAST = BW'(NB - 1);

  if (N_BYTES % LANES != 0) begin : g_bad_lanes
    $error("sub_bytes_iter: N_BYTES must be a multiple of LANES");
  end

  localparam logic [0:255][7:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef INV_SBOX_EN
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [8*N_BYTES-1:0] work_q, work_d, work_sub;
  logic [8*N_BYTES-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 accept;

`ifdef INV_SBOX_EN
  logic mode_q, mode_d;
`else
  logic unused_inverse;
  assign unused_inverse = in_inverse;
`endif

  // Byte 0 sits in the top bits, so lane l of beat b is byte b*LANES+l.
  function automatic logic [IW-1:0] lane_lsb(input logic [BW-1:0] beat,
                                             input int l);
    return IW'(8 * (N_BYTES - 1 - (int'(beat) * LANES + l)));
  endfunction

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q;
  assign out_block = out_q;
  assign busy      = (state_q == RUN);

  always_comb begin
    work_sub = work_q;
    for (int l = 0; l < LANES; l++) begin
`ifdef INV_SBOX_EN
      work_sub[lane_lsb(beat_q, l) +: 8] = mode_q
        ? INV_SBOX[work_q[lane_lsb(beat_q, l) +: 8]]
        : FWD_SBOX[work_q[lane_lsb(beat_q, l) +: 8]];
`else
      work_sub[lane_lsb(beat_q, l) +: 8] =
        FWD_SBOX[work_q[lane_lsb(beat_q, l) +: 8]];
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    work_d  = work_q;
    out_d   = out_q;
    valid_d = valid_q;
`ifdef INV_SBOX_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        work_d = work_sub;
        if (beat_q == LAST) begin
          out_d   = work_sub;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A DONE-state accept overrides the drain so no idle gap appears.
    if (accept) begin
      state_d = RUN;
      beat_d  = '0;
      work_d  = in_block;
`ifdef INV_SBOX_EN
      mode_d  = in_inverse;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      work_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
`ifdef INV_SBOX_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      work_q  <= work_d;
      out_q   <= out_d;
      valid_q <= valid_d;
`ifdef INV_SBOX_EN
      mode_q  <= mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: LANES=4, 1 and 16 instances against a GF(2^8) model.
// S-box reference is derived from field inversion plus the affine map.
module tb_sub_bytes_iter;

  logic         clk;
  logic         rst;
  logic         vld  [3];
  logic         rdy  [3];
  logic         inv  [3];
  logic [127:0] din  [3];
  logic         ovl  [3];
  logic         ordy [3];
  logic [127:0] dout [3];
  logic         bsy  [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  sub_bytes_iter #(.LANES(4), .N_BYTES(16)) u_l4 (
    .clock(clk), .reset(rst),
    .in_valid(vld[0]), .in_ready(rdy[0]), .in_inverse(inv[0]),
    .in_block(din[0]), .out_valid(ovl[0]), .out_ready(ordy[0]),
    .out_block(dout[0]), .busy(bsy[0])
  );

  sub_bytes_iter #(.LANES(1), .N_BYTES(16)) u_l1 (
    .clock(clk), .reset(rst),
    .in_valid(vld[1]), .in_ready(rdy[1]), .in_inverse(inv[1]),
    .in_block(din[1]), .out_valid(ovl[1]), .out_ready(ordy[1]),
    .out_block(dout[1]), .busy(bsy[1])
  );

  sub_bytes_iter #(.LANES(16), .N_BYTES(16)) u_l16 (
    .clock(clk), .reset(rst),
    .in_valid(vld[2]), .in_ready(rdy[2]), .in_inverse(inv[2]),
    .in_block(din[2]), .out_valid(ovl[2]), .out_ready(ordy[2]),
    .out_block(dout[2]), .busy(bsy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic iv);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      b = d[127-8*j -: 8];
      r[127-8*j -: 8] = iv ? inv_t[b] : fwd_t[b];
    end
    return r;
  endfunction

  function automatic logic eff_inv(input logic iv);
`ifdef INV_SBOX_EN
    return iv;
`else
    return 1'b0 & iv;
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the instance idle; returns at a negedge, idle.
  task automatic xfer(input int k, input logic [127:0] d, input logic iv,
                      input int hold, input logic [127:0] exp,
                      input int exp_lat, input string name);
    int n;
    int lat;
    n = 0;
    while (!rdy[k] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept_ready"}, rdy[k], 1'b1);
    din[k] = d;
    inv[k] = iv;
    vld[k] = 1'b1;
    @(negedge clk);
    vld[k] = 1'b0;
    inv[k] = ~iv;
    din[k] = ~d;
    chk({name, "_run_busy_ready"}, {bsy[k], rdy[k]}, 2'b10);
    lat = 0;
    while (!ovl[k] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_block"}, dout[k], exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, ovl[k], 1'b1);
      chk({name, "_hold_block"}, dout[k], exp);
      chk({name, "_hold_ready"}, rdy[k], 1'b0);
    end
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    chk({name, "_drain_idle"}, {ovl[k], rdy[k], bsy[k]}, 3'b010);
  endtask

  typedef struct {
    int           k;
    logic [127:0] d;
    logic         iv;
    logic [127:0] e;
    int           lat;
  } vec_t;

  vec_t tv [6];

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam int NBS [3] = '{4, 16, 1};

  initial begin
    logic [127:0] rd;
    logic         riv;
    int           rk;
    int           n;

    for (int i = 0; i < 256; i++) begin
      fwd_t[i] = affine(ginv(8'(i)));
      inv_t[fwd_t[i]] = 8'(i);
    end

    tv[0] = '{0, PT, 1'b0, CT, 4};
`ifdef INV_SBOX_EN
    tv[1] = '{0, CT, 1'b1, PT, 4};
`else
    tv[1] = '{0, CT, 1'b1, model(CT, 1'b0), 4};
`endif
    tv[2] = '{0, 128'h0, 1'b0, {16{8'h63}}, 4};
    tv[3] = '{2, {16{8'h53}}, 1'b0, {16{8'hed}}, 1};
    tv[4] = '{1, {16{8'h53}}, 1'b0, {16{8'hed}}, 16};
    tv[5] = '{0, {16{8'hff}}, 1'b0, {16{8'h16}}, 4};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0; inv[k] = 1'b0; din[k] = '0; ordy[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", rdy[k], 1'b1);
      chk("reset_valid_busy", {ovl[k], bsy[k]}, 2'b00);
      chk("reset_block", dout[k], '0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      xfer(tv[i].k, tv[i].d, tv[i].iv, 0, tv[i].e, tv[i].lat, $sformatf("vec%0d", i));

    xfer(0, PT, 1'b0, 10, CT, 4, "hold10");

    // Back-to-back: accept a zero block in the same cycle the result drains.
    din[0] = PT; inv[0] = 1'b0; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    n = 0;
    while (!ovl[0] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first", dout[0], CT);
    din[0] = '0; vld[0] = 1'b1; ordy[0] = 1'b1;
    #1;
    chk("b2b_ready", rdy[0], 1'b1);
    @(negedge clk);
    vld[0] = 1'b0; ordy[0] = 1'b0;
    chk("b2b_restart", {ovl[0], bsy[0]}, 2'b01);
    n = 0;
    while (!ovl[0] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_latency", n, 4);
    chk("b2b_block", dout[0], {16{8'h63}});
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;

    // Reset during beat 2 discards the partial block.
    din[0] = PT; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun_busy", bsy[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_valid", ovl[0], 1'b0);
    chk("rst_block", dout[0], '0);
    chk("rst_ready_busy", {rdy[0], bsy[0]}, 2'b10);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer(0, PT, 1'b0, 0, CT, 4, "post_rst");

    for (int i = 0; i < 24; i++) begin
      rk  = $urandom_range(0, 2);
      rd  = {$urandom, $urandom, $urandom, $urandom};
      riv = 1'($urandom_range(0, 1));
      xfer(rk, rd, riv, $urandom_range(0, 2), model(rd, eff_inv(riv)),
           NBS[rk], $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
